// File: rtl/tff_bank_ctrl_if.sv
// Command handshake between the datapath controller (master) and the
// T-flip-flop bank sequencer (slave).
interface tff_bank_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/tff_bank_ctrl.sv
// Sequencer for a T-flip-flop register bank: turns word commands into a
// one-tick toggle vector, reads the bank back and retries on mismatch.
module tff_bank_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    tff_bank_ctrl_if.slave   cmd,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] t_o,
    output logic             tick_o,
    output logic             done_o,
    output logic             resp_err_o,
    output logic             err_sticky_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [2:0] OpLoad  = 3'd0;
    localparam logic [2:0] OpClear = 3'd1;
    localparam logic [2:0] OpSet   = 3'd2;
    localparam logic [2:0] OpInc   = 3'd3;
    localparam logic [2:0] OpDec   = 3'd4;
    localparam logic [2:0] OpShl   = 3'd5;
    localparam logic [2:0] OpShr   = 3'd6;
    localparam logic [2:0] OpInv   = 3'd7;

    localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

    typedef enum logic [1:0] {StIdle, StCalc, StApply, StCheck} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [2:0]       retry_q, retry_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             resp_err_q, resp_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] calc_target;

    always_comb begin
        calc_target = data_q;
        unique case (op_q)
            OpLoad:  calc_target = data_q;
            OpClear: calc_target = '0;
            OpSet:   calc_target = '1;
            OpInc:   calc_target = q_i + WIDTH'(1);
            OpDec:   calc_target = q_i - WIDTH'(1);
            OpShl:   calc_target = {q_i[WIDTH-2:0], data_q[0]};
            OpShr:   calc_target = {data_q[0], q_i[WIDTH-1:1]};
            OpInv:   calc_target = ~q_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        data_d       = data_q;
        target_d     = target_q;
        retry_d      = retry_q;
        t_d          = t_q;
        tick_d       = tick_q;
        done_d       = 1'b0;
        resp_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        result_d     = result_q;

        unique case (state_q)
            StIdle: begin
                if (cmd.cmd_valid) begin
                    op_d    = cmd.cmd_op;
                    data_d  = cmd.cmd_data;
                    retry_d = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                // A retry re-applies the original target against the live bank.
                target_d = (retry_q == '0) ? calc_target : target_q;
                t_d      = target_d ^ q_i;
                tick_d   = 1'b1;
                state_d  = StApply;
            end
            StApply: begin
                t_d     = '0;
                tick_d  = 1'b0;
                state_d = StCheck;
            end
            StCheck: begin
                if (q_i == target_q) begin
                    done_d   = 1'b1;
                    result_d = target_q;
                    state_d  = StIdle;
                end else if (retry_q < MaxRetry) begin
                    retry_d = retry_q + 3'd1;
                    state_d = StCalc;
                end else begin
                    done_d       = 1'b1;
                    resp_err_d   = 1'b1;
                    err_sticky_d = 1'b1;
                    result_d     = target_q;
                    state_d      = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            op_q         <= '0;
            data_q       <= '0;
            target_q     <= '0;
            retry_q      <= '0;
            t_q          <= '0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
            resp_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            data_q       <= data_d;
            target_q     <= target_d;
            retry_q      <= retry_d;
            t_q          <= t_d;
            tick_q       <= tick_d;
            done_q       <= done_d;
            resp_err_q   <= resp_err_d;
            err_sticky_q <= err_sticky_d;
            result_q     <= result_d;
        end
    end

    assign cmd.cmd_ready = (state_q == StIdle);
    assign t_o           = t_q;
    assign tick_o        = tick_q;
    assign done_o        = done_q;
    assign resp_err_o    = resp_err_q;
    assign err_sticky_o  = err_sticky_q;
    assign result_o      = result_q;

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Directed bench for tff_bank_ctrl with a behavioural T-flip-flop bank model.
module tb_tff_bank_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] bank = '0;
    logic             bank_en = 1'b1;
    logic [WIDTH-1:0] t_o;
    logic             tick_o;
    logic             done_o;
    logic             resp_err_o;
    logic             err_sticky_o;
    logic [WIDTH-1:0] result_o;
    int               n_checks = 0;
    int               n_errors = 0;

    tff_bank_ctrl_if #(.WIDTH(WIDTH)) cif ();

    tff_bank_ctrl #(.WIDTH(WIDTH), .MAX_RETRY(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd         (cif.slave),
        .q_i         (bank),
        .t_o         (t_o),
        .tick_o      (tick_o),
        .done_o      (done_o),
        .resp_err_o  (resp_err_o),
        .err_sticky_o(err_sticky_o),
        .result_o    (result_o)
    );

    always #5 clk = ~clk;

    // Bank model: toggles on the edge where the tick is high, unless disabled.
    always @(posedge clk) begin
        if (tick_o && bank_en) bank <= bank ^ t_o;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Starts just after a negedge with the DUT idle; ends one cycle after DONE.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] data,
                           input logic [7:0] exp_t, input logic [7:0] exp_res);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = data;
        check1({tag, " ready0"}, cif.cmd_ready, 1'b1);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        check1({tag, " tick1"}, tick_o, 1'b0);
        check1({tag, " ready1"}, cif.cmd_ready, 1'b0);
        @(negedge clk);
        check1({tag, " tick2"}, tick_o, 1'b1);
        check8({tag, " t2"}, t_o, exp_t);
        @(negedge clk);
        check1({tag, " tick3"}, tick_o, 1'b0);
        check8({tag, " t3"}, t_o, 8'h00);
        check1({tag, " done3"}, done_o, 1'b0);
        @(negedge clk);
        check1({tag, " done4"}, done_o, 1'b1);
        check1({tag, " err4"}, resp_err_o, 1'b0);
        check8({tag, " result4"}, result_o, exp_res);
        check1({tag, " ready4"}, cif.cmd_ready, 1'b1);
        @(negedge clk);
        check1({tag, " done5"}, done_o, 1'b0);
        check8({tag, " bank"}, bank, exp_res);
    endtask

    initial begin
        logic e;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 3'd0;
        cif.cmd_data  = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check1("rst tick", tick_o, 1'b0);
        check8("rst t", t_o, 8'h00);
        check1("rst done", done_o, 1'b0);
        check1("rst err", resp_err_o, 1'b0);
        check1("rst sticky", err_sticky_o, 1'b0);
        check8("rst result", result_o, 8'h00);
        check1("rst ready", cif.cmd_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Opcode sweep through the real bank
        run_cmd("load a5", 3'd0, 8'hA5, 8'hA5, 8'hA5);
        run_cmd("load ff", 3'd0, 8'hFF, 8'h5A, 8'hFF);
        run_cmd("inc wrap", 3'd3, 8'h00, 8'hFF, 8'h00);
        run_cmd("dec wrap", 3'd4, 8'h00, 8'hFF, 8'hFF);
        run_cmd("load 81", 3'd0, 8'h81, 8'h7E, 8'h81);
        run_cmd("shl", 3'd5, 8'h01, 8'h82, 8'h03);
        run_cmd("shr", 3'd6, 8'hFE, 8'h02, 8'h01);
        run_cmd("load 3c", 3'd0, 8'h3C, 8'h3D, 8'h3C);
        run_cmd("inv", 3'd7, 8'h00, 8'hFF, 8'hC3);
        run_cmd("set", 3'd2, 8'h00, 8'h3C, 8'hFF);
        run_cmd("clear", 3'd1, 8'hAA, 8'hFF, 8'h00);
        check1("sticky clean", err_sticky_o, 1'b0);

        // Dead bank: every verify fails, two retries then error
        bank_en = 1'b0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 3'd0;
        cif.cmd_data  = 8'h0F;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            cif.cmd_valid = 1'b0;
            e = (c == 2) || (c == 5) || (c == 8);
            check1($sformatf("retry tick c%0d", c), tick_o, e);
            if (e) check8($sformatf("retry t c%0d", c), t_o, 8'h0F);
            e = (c == 10);
            check1($sformatf("retry done c%0d", c), done_o, e);
        end
        check1("retry err", resp_err_o, 1'b1);
        check8("retry result", result_o, 8'h0F);
        check1("retry sticky", err_sticky_o, 1'b1);
        bank_en = 1'b1;
        @(negedge clk);
        check1("retry err cleared", resp_err_o, 1'b0);
        check1("sticky holds", err_sticky_o, 1'b1);

        // Valid held across a busy command; second op taken in the DONE cycle
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 3'd0;
        cif.cmd_data  = 8'h55;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) cif.cmd_op = 3'd1;
            if (c == 5) cif.cmd_valid = 1'b0;
            e = (c == 4);
            check1($sformatf("b2b ready c%0d", c), cif.cmd_ready, e || (c == 8));
            e = (c == 4) || (c == 8);
            check1($sformatf("b2b done c%0d", c), done_o, e);
            if (c == 2) check8("b2b t1", t_o, 8'h55);
            if (c == 4) check8("b2b result1", result_o, 8'h55);
            if (c == 6) check8("b2b t2", t_o, 8'h55);
            if (c == 8) check8("b2b result2", result_o, 8'h00);
        end
        @(negedge clk);
        check8("b2b bank", bank, 8'h00);
        check1("b2b sticky", err_sticky_o, 1'b1);

        // Reset during APPLY drops the tick asynchronously
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 3'd0;
        cif.cmd_data  = 8'hAA;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        @(negedge clk);
        check1("arst tick before", tick_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check1("arst tick async", tick_o, 1'b0);
        check8("arst t async", t_o, 8'h00);
        check1("arst sticky", err_sticky_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check8("arst bank", bank, 8'h00);
        for (int c = 0; c < 4; c++) begin
            check1($sformatf("arst no done c%0d", c), done_o, 1'b0);
            check1($sformatf("arst ready c%0d", c), cif.cmd_ready, 1'b1);
            @(negedge clk);
        end

        // Zero toggle still ticks and completes normally
        run_cmd("zero", 3'd0, 8'h00, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
